// File: rtl/frame_deserializer.sv
// frame_deserializer: assembles MSB-first serial bits into framed samples behind a show-ahead FIFO
module frame_deserializer #(
  parameter int SAMPLE_W   = 16,
  parameter int FRAME_BITS = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic                frame_sync,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_last,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                locked,
  output logic                sync_err,
  output logic                overflow
);
  localparam int NS = FRAME_BITS / SAMPLE_W;
  localparam int BW = $clog2(SAMPLE_W);
  localparam int SW = NS > 1 ? $clog2(NS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t              state;
  logic [BW-1:0]       bit_cnt;
  logic [SW-1:0]       samp_cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [AW:0]         count;
  logic                start, realign, push, last, pop, full, push_ok;
  logic [SAMPLE_W-1:0] next_data;
  // framing decisions and FIFO handshake for the current cycle
  always_comb begin
    start     = bit_valid && frame_sync && (state == UNLOCKED || bit_cnt != '0 || samp_cnt != '0);
    realign   = start && state == LOCKED;
    push      = state == LOCKED && bit_valid && !start && bit_cnt == BW'(SAMPLE_W - 1);
    last      = samp_cnt == SW'(NS - 1);
    next_data = {shreg[SAMPLE_W-2:0], bit_in};
    pop       = count != '0 && sample_ready;
    full      = count == (AW+1)'(FIFO_DEPTH);
    push_ok   = push && (!full || pop);
  end
  // lock state, bit/sample counters, FIFO pointers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNLOCKED;
      bit_cnt  <= '0;
      samp_cnt <= '0;
      shreg    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      sync_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync_err <= realign;
      if (start) begin
        state    <= LOCKED;
        bit_cnt  <= BW'(1);
        samp_cnt <= '0;
        shreg    <= SAMPLE_W'(bit_in);
      end else if (state == LOCKED && bit_valid) begin
        shreg    <= next_data;
        bit_cnt  <= push ? '0 : bit_cnt + BW'(1);
        samp_cnt <= push ? (last ? '0 : samp_cnt + SW'(1)) : samp_cnt;
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end
  // FIFO storage; entries beyond the pointers are never observed, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {last, next_data};
  end
  assign sample_valid              = count != '0;
  assign {sample_last, sample_out} = sample_valid ? mem[rd_ptr] : '0;
  assign locked                    = state == LOCKED;
endmodule
